// File: rtl/cpu_trace_buffer.sv
// Writeback trace capture: records retired register writes into a circular
// buffer during a bounded capture window, with a pop-style readout port.
module cpu_trace_buffer #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       mode,
  input  logic                       wb_valid,
  input  logic [PC_W-1:0]            wb_pc,
  input  logic [REG_AW-1:0]          wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [PC_W-1:0]            rd_pc,
  output logic [REG_AW-1:0]          rd_reg,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic [CYC_W-1:0]           cycle_count,
  output logic [1:0]                 state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic                mode_q, mode_d;
  logic                rd_valid_q, rd_valid_d;
  logic [PC_W-1:0]     rd_pc_q, rd_pc_d;
  logic [REG_AW-1:0]   rd_reg_q, rd_reg_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                mem_we;
  logic                wr_req;
  logic                rd_req;
  logic                is_full;
  logic                is_empty;

  logic [PC_W-1:0]     pc_mem   [DEPTH];
  logic [REG_AW-1:0]   reg_mem  [DEPTH];
  logic [DATA_W-1:0]   data_mem [DEPTH];

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    cyc_d      = cyc_q;
    mode_d     = mode_q;
    rd_valid_d = 1'b0;
    rd_pc_d    = rd_pc_q;
    rd_reg_d   = rd_reg_q;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    wr_req     = 1'b0;
    rd_req     = 1'b0;

    if (arm) begin
      state_d    = ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      cyc_d      = '0;
      mode_d     = mode;
    end else begin
      wr_req = (state_q == ARMED) && wb_valid;
      rd_req = rd_en && !is_empty;

      if (rd_req) begin
        rd_valid_d = 1'b1;
        rd_pc_d    = pc_mem[rd_ptr_q];
        rd_reg_d   = reg_mem[rd_ptr_q];
        rd_data_d  = data_mem[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + AW'(1);
      end

      // A write into a full buffer with no concurrent pop either evicts the
      // oldest entry (wrap) or is dropped and ends capture (stop).
      if (wr_req) begin
        if (is_full && !rd_req) begin
          overflow_d = 1'b1;
          if (mode_q) begin
            state_d = DONE;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (!rd_req) count_d = count_q + CW'(1);
        end
      end else if (rd_req) begin
        count_d = count_q - CW'(1);
      end

      if (state_q == ARMED) begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_d == CYC_W'(MAX_CYCLES)) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cyc_q      <= '0;
      mode_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_reg_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cyc_q      <= cyc_d;
      mode_q     <= mode_d;
      rd_valid_q <= rd_valid_d;
      rd_pc_q    <= rd_pc_d;
      rd_reg_q   <= rd_reg_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      pc_mem[wr_ptr_q]   <= wb_pc;
      reg_mem[wr_ptr_q]  <= wb_reg;
      data_mem[wr_ptr_q] <= wb_data;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_pc       = rd_pc_q;
  assign rd_reg      = rd_reg_q;
  assign rd_data     = rd_data_q;
  assign count       = count_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign overflow    = overflow_q;
  assign cycle_count = cyc_q;
  assign state_o     = state_q;

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable writeback-trace capture unit for the pipelined CPU. Records every retired register write (PC, destination register, data) into a parametrised circular buffer, bounded by a programmable cycle budget, replacing the fixed-time register dump of the CPU bench with a readable, self-contained trace. Sits beside the CPU, tapping the writeback stage, with a pop-style readout port for the bench or a debug host.

## Interface
- DATA_W, 32, register data width
- PC_W, 32, program counter width
- REG_AW, 3, register index width (8 registers)
- DEPTH, 16, buffer entries; power of two, >= 2
- CYC_W, 16, cycle counter width
- MAX_CYCLES, 15, capture window in cycles after arm; 1..2^CYC_W-1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  pulse: flush buffer, clear flags, start capture window
- mode  in  1  0 = wrap (overwrite oldest), 1 = stop when full; sampled on arm only
- wb_valid  in  1  writeback retires this cycle
- wb_pc  in  PC_W  PC of retiring instruction
- wb_reg  in  REG_AW  destination register
- wb_data  in  DATA_W  value written
- rd_en  in  1  pop oldest entry
- rd_valid  out  1  rd_* holds popped entry (one-cycle pulse)
- rd_pc / rd_reg / rd_data  out  PC_W / REG_AW / DATA_W  popped entry
- count  out  $clog2(DEPTH)+1  entries held
- empty / full  out  1  count==0 / count==DEPTH
- overflow  out  1  sticky: at least one entry lost (overwritten or dropped)
- cycle_count  out  CYC_W  cycles elapsed in current window
- state_o  out  2  IDLE=0, ARMED=1, DONE=2

## Operation
- FSM: IDLE -> ARMED on arm. ARMED -> DONE when cycle_count reaches MAX_CYCLES, or (mode=1) on first write dropped while full. DONE -> ARMED on arm. arm in ARMED restarts window. No other transitions.
- arm (any state): wr/rd pointers, count, overflow, cycle_count cleared; latched mode updated; rd_en and wb_valid in that cycle ignored.
- Capture only in ARMED with wb_valid=1; entry {wb_pc, wb_reg, wb_data} written at write pointer. Register-0 writes captured like any other.
- Full, write, no pop: mode 0 -> overwrite oldest, advance both pointers, count stays DEPTH, overflow=1; mode 1 -> entry dropped, overflow=1, go DONE.
- Full, write and pop same cycle: pop returns oldest, write stored, count unchanged, no overflow.
- Empty, write and pop same cycle: pop ignored (rd_valid=0), write stored, count=1.
- Pop when empty: no effect, rd_valid=0, rd_* hold previous value.
- Reads permitted in all states; capture ends at DONE but buffer remains readable.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- cycle_count increments each ARMED cycle, frozen in IDLE/DONE; it is the count of completed ARMED cycles since arm.

## Timing
- Reset: state_o=IDLE, count=0, empty=1, full=0, overflow=0, cycle_count=0, rd_valid=0, rd_pc/rd_reg/rd_data=0, latched mode=0.
- arm at edge N: state_o=ARMED, all clears visible after N. First capturable wb_valid at edge N+1.
- Write latency: entry counted (count/empty/full update) after the edge sampling wb_valid.
- Read latency: rd_en sampled at edge N -> rd_valid=1 and rd_* valid after N, for one cycle.
- Window: after arm at edge N, cycle_count=k after edge N+k; on edge N+MAX_CYCLES cycle_count=MAX_CYCLES and state_o=DONE; a wb_valid sampled on that edge is still captured; later ones are not.
- Flags are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then rst high mid-ARMED with 3 entries -> next cycle all outputs at reset values, state_o=IDLE.
- DEPTH=16, mode 0, arm, 5 writes pc=0x00,0x04..0x10, reg=1..5, data=0xA1..0xA5, then 5 pops -> rd entries returned in order, count 5->0, empty=1, overflow=0.
- mode 0, 18 writes data 1..18, no pops -> count=16, full=1, overflow=1; pops return data 3..18.
- mode 1, 17 writes -> 17th dropped, overflow=1, state_o=DONE; pops return data 1..16; further wb_valid ignored.
- Full buffer, simultaneous write(data 0x99) and pop -> pop returns oldest, count stays 16, overflow=0; empty buffer simultaneous write+pop -> rd_valid=0, count=1.
- MAX_CYCLES=15, wb_valid held high from cycle after arm -> exactly 15 entries captured, state_o=DONE, cycle_count=15; re-arm -> count=0, cycle_count=0, state_o=ARMED.
